// File: rtl/reset_sequencer_pkg.sv
// Shared state and cause encodings for the board reset scheduler, plus
// default timing parameters and a counter-width helper.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_STAGGER = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_POR    = 2'd0;
  localparam logic [1:0] CAUSE_BUTTON = 2'd1;
  localparam logic [1:0] CAUSE_SW     = 2'd2;

  localparam int DEF_HOLD_CYCLES     = 16;
  localparam int DEF_STAGGER_CYCLES  = 8;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reset_sequencer_button_debouncer.sv
// Front-panel button conditioning: two-flop synchroniser followed by a
// stability counter that accepts a level only after a run of equal samples.
module button_debouncer
  import reset_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw_n,
  output logic o_pressed,
  output logic o_press_event
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_n;
  logic          sync2_n;
  logic          level_n;
  logic [CW-1:0] stable_cnt;
  logic          settle;

  // The sample that completes the run flips the level on this same edge.
  assign settle = (sync2_n != level_n) && (stable_cnt == LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1_n    <= 1'b1;
      sync2_n    <= 1'b1;
      level_n    <= 1'b1;
      stable_cnt <= '0;
    end else begin
      sync1_n <= i_raw_n;
      sync2_n <= sync1_n;
      if (sync2_n == level_n) begin
        stable_cnt <= '0;
      end else if (settle) begin
        level_n    <= sync2_n;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

  assign o_pressed     = ~level_n;
  assign o_press_event = settle & level_n;

endmodule

// File: rtl/reset_sequencer.sv
// Board reset scheduler: merges POR, front-panel button and software reset
// into a staged release, peripherals first and the Z80 /RESET later.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int STAGGER_CYCLES  = DEF_STAGGER_CYCLES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_button_n,
  input  logic       i_sw_reset_req,
  output logic       o_periph_reset_n,
  output logic       o_cpu_reset_n,
  output logic       o_busy,
  output logic [1:0] o_cause
);

  localparam int MAXC = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CW   = cnt_w(MAXC);
  localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER_CYCLES - 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [1:0]    cause_next;
  logic          pressed;
  logic          press_event;
  logic          trig_button;
  logic          trigger;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_button (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_raw_n      (i_button_n),
    .o_pressed    (pressed),
    .o_press_event(press_event)
  );

  assign trig_button = pressed | press_event;
  assign trigger     = trig_button | i_sw_reset_req;

  always_comb begin
    state_next = state;
    count_next = count;
    cause_next = o_cause;
    if (trigger) begin
      state_next = ST_ASSERT;
      count_next = '0;
      cause_next = trig_button ? CAUSE_BUTTON : CAUSE_SW;
    end else begin
      case (state)
        ST_ASSERT: begin
          if (count == HOLD_LAST) begin
            state_next = ST_STAGGER;
            count_next = '0;
          end else begin
            count_next = count + 1'b1;
          end
        end
        ST_STAGGER: begin
          if (count == STAGGER_LAST) begin
            state_next = ST_RUN;
            count_next = '0;
          end else begin
            count_next = count + 1'b1;
          end
        end
        ST_RUN: count_next = '0;
        default: begin
          state_next = ST_ASSERT;
          count_next = '0;
        end
      endcase
    end
  end

  // Outputs are registered decodes of the next state so they track the state flop exactly.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state            <= ST_ASSERT;
      count            <= '0;
      o_cause          <= CAUSE_POR;
      o_periph_reset_n <= 1'b0;
      o_cpu_reset_n    <= 1'b0;
      o_busy           <= 1'b1;
    end else begin
      state            <= state_next;
      count            <= count_next;
      o_cause          <= cause_next;
      o_periph_reset_n <= (state_next != ST_ASSERT);
      o_cpu_reset_n    <= (state_next == ST_RUN);
      o_busy           <= (state_next != ST_RUN);
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: scenario tasks plus randomized traffic, all
// checked against an "edges since last trigger" reference model.
module tb_reset_sequencer;

  localparam int H = 4;
  localparam int S = 3;
  localparam int D = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       button_n = 1'b1;
  logic       sw_req = 1'b0;
  logic       periph_n;
  logic       cpu_n;
  logic       busy;
  logic [1:0] cause;

  int n_checks = 0;
  int n_fail   = 0;

  reset_sequencer #(
    .HOLD_CYCLES    (H),
    .STAGGER_CYCLES (S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_button_n      (button_n),
    .i_sw_reset_req  (sw_req),
    .o_periph_reset_n(periph_n),
    .o_cpu_reset_n   (cpu_n),
    .o_busy          (busy),
    .o_cause         (cause)
  );

  always #5 clk = ~clk;

  // Reference model: release times follow from edges elapsed since the last trigger.
  int         since = 0;
  logic       mlevel = 1'b0;
  logic [1:0] mcause = 2'b00;
  bit         raw_hist[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      since  = 0;
      mcause = 2'b00;
      mlevel = 1'b0;
      raw_hist.delete();
      for (int i = 0; i < 2 + D; i++) raw_hist.push_back(1'b1);
    end else begin
      bit flip;
      bit btn;
      raw_hist.push_front(button_n);
      while (raw_hist.size() > 2 + D) void'(raw_hist.pop_back());
      flip = 1'b1;
      for (int j = 0; j < D; j++)
        if ((!raw_hist[2 + j]) == mlevel) flip = 1'b0;
      btn = mlevel | (flip & !mlevel);
      if (flip) mlevel = !mlevel;
      if (btn || sw_req) begin
        since  = 0;
        mcause = btn ? 2'b01 : 2'b10;
      end else if (since < 1000) begin
        since = since + 1;
      end
    end
  end

  logic [4:0] exp_v;
  logic [4:0] act_v;
  assign exp_v = {since >= H, since >= H + S, since < H + S, mcause};
  assign act_v = {periph_n, cpu_n, busy, cause};

  task automatic wait_run(output bit ok);
    ok = 1'b0;
    button_n = 1'b1;
    sw_req   = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (act_v !== 5'b00100) begin
      n_fail++;
      $display("FAIL reset_hold got=%b want=00100", act_v);
    end
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      logic [4:0] want;
      @(negedge clk);
      want = {k >= 4, k >= 7, k < 7, 2'b00};
      n_checks++;
      if (act_v !== want) begin
        n_fail++;
        $display("FAIL por_seq edge=%0d got=%b want=%b", k, act_v, want);
      end
    end
  endtask

  task automatic test_button_glitch();
    bit ok;
    wait_run(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL glitch_wait_run got=busy want=idle"); end
    button_n = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_checks++;
      if ({periph_n, cpu_n} !== 2'b11 || act_v !== exp_v) begin
        n_fail++;
        $display("FAIL glitch k=%0d got=%b want=%b", k, act_v, exp_v);
      end
      if (k == 2) button_n = 1'b1;
    end
    button_n = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL button_hold k=%0d got=%b want=%b", k, act_v, exp_v);
      end
      if (k == 4 || k == 5 || k == 18 || k == 19 || k == 21 || k == 22) begin
        logic [4:0] want;
        case (k)
          4:       want = {1'b1, 1'b1, 1'b0, cause};
          5:       want = 5'b00101;
          18:      want = 5'b00101;
          19:      want = 5'b10101;
          21:      want = 5'b10101;
          default: want = 5'b11001;
        endcase
        n_checks++;
        if (act_v !== want) begin
          n_fail++;
          $display("FAIL button_timing k=%0d got=%b want=%b", k, act_v, want);
        end
      end
      if (k == 10) button_n = 1'b1;
    end
  endtask

  task automatic test_sw_reset();
    bit ok;
    wait_run(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL sw_wait_run got=busy want=idle"); end
    sw_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      sw_req = 1'b0;
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL sw_model k=%0d got=%b want=%b", k, act_v, exp_v);
      end
      if (k == 1 || k == 4 || k == 5 || k == 7 || k == 8) begin
        logic [4:0] want;
        want = {k >= 5, k >= 8, k < 8, 2'b10};
        n_checks++;
        if (act_v !== want) begin
          n_fail++;
          $display("FAIL sw_timing k=%0d got=%b want=%b", k, act_v, want);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    wait_run(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL simul_wait_run got=busy want=idle"); end
    button_n = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL simul_model k=%0d got=%b want=%b", k, act_v, exp_v);
      end
      if (k == 5 || k == 11 || k == 12 || k == 15) begin
        logic [4:0] want;
        case (k)
          5, 11:   want = 5'b00101;
          12:      want = 5'b10101;
          default: want = 5'b11001;
        endcase
        n_checks++;
        if (act_v !== want) begin
          n_fail++;
          $display("FAIL simul_timing k=%0d got=%b want=%b", k, act_v, want);
        end
      end
      if (k == 3) button_n = 1'b1;
      sw_req = (k == 4);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_run(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL mid_wait_run got=busy want=idle"); end
    sw_req = 1'b1;
    @(negedge clk);
    sw_req = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({periph_n, cpu_n} !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_in_stagger got=%b want=10", {periph_n, cpu_n});
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (act_v !== 5'b00100) begin
      n_fail++;
      $display("FAIL mid_async got=%b want=00100", act_v);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      logic [4:0] want;
      @(negedge clk);
      want = {k >= 4, k >= 7, k < 7, 2'b00};
      n_checks++;
      if (act_v !== want || act_v !== exp_v) begin
        n_fail++;
        $display("FAIL mid_seq k=%0d got=%b want=%b", k, act_v, want);
      end
    end
  endtask

  task automatic test_retrigger();
    bit ok;
    wait_run(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL retrig_wait_run got=busy want=idle"); end
    sw_req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      sw_req = (k == 3);
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL retrig_model k=%0d got=%b want=%b", k, act_v, exp_v);
      end
      if (k == 4 || k == 5 || k == 7 || k == 8 || k == 10 || k == 11) begin
        logic [4:0] want;
        want = {k >= 8, k >= 11, k < 11, 2'b10};
        n_checks++;
        if (act_v !== want) begin
          n_fail++;
          $display("FAIL retrig_timing k=%0d got=%b want=%b", k, act_v, want);
        end
      end
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL random k=%0d got=%b want=%b", k, act_v, exp_v);
      end
      if (hold == 0) begin
        button_n = ($urandom_range(0, 2) != 0);
        hold     = $urandom_range(1, 8);
      end else begin
        hold--;
      end
      sw_req = ($urandom_range(0, 24) == 0);
    end
    button_n = 1'b1;
    sw_req   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_button_glitch();
    test_sw_reset();
    test_simultaneous();
    test_reset_mid();
    test_retrigger();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
